tape_ram_writer: RTL and testbench
==================================

# tape_ram_writer

Downstream stage of the cassette TAP loader. Takes the loader's level-style write stream (`tape_wr`/`tape_addr`/`tape_dout`) and buffers each new byte in a small FIFO. Commits buffered bytes to Lynx main RAM only in cycles the CPU does not own the RAM port. Raises `ioctl_wait` to throttle the HPS download before the FIFO can overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `AW`, 16: RAM address width.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `tape_wr`  in  1  loader write enable; level, may stay high across many bytes.
- `tape_addr`  in  AW  loader byte address.
- `tape_dout`  in  8  loader byte data.
- `cpu_busy`  in  1  CPU owns the RAM port this cycle; no commit allowed.
- `ram_we`  out  1  one-cycle RAM write strobe.
- `ram_addr`  out  AW  RAM write address, valid while `ram_we`=1.
- `ram_din`  out  8  RAM write data, valid while `ram_we`=1.
- `ioctl_wait`  out  1  throttle request to the HPS download.
- `busy`  out  1  FIFO non-empty or a commit in flight.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `wr_sum`  out  8  checksum of committed bytes (see Configuration).
- `wr_count`  out  16  count of committed bytes (see Configuration).

## Operation
- **Push detection.** A new byte is accepted in a cycle when `tape_wr`=1 and either:
  - `tape_wr` was 0 in the previous cycle, or
  - `tape_addr` differs from the last accepted address.
  - Registered `last_addr`/`prev_wr` hold this history. Consecutive identical addresses while `tape_wr` stays high are one byte.
- **FIFO.** Circular buffer of {addr, data}. Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty. A `count` register tracks occupancy.
- **Pop/commit.** When the FIFO is non-empty and `cpu_busy`=0:
  - pop the head entry;
  - register it onto `ram_addr`/`ram_din`;
  - assert `ram_we` for exactly one cycle.
  - Pops may occur every cycle.
- **Arbitration.** `cpu_busy`=1 suppresses the pop. Buffered data is held without loss for any number of cycles.
- **Simultaneous push and pop.** Both occur; count is unchanged. This holds when full, because pop frees a slot in the same cycle. Holds when empty only if the entry was already present; a push never bypasses to `ram_we` in the same cycle.
- **Full.** A push with the FIFO full and no pop in that cycle discards the byte and sets `overflow`. `overflow` clears only on reset.
- **Throttle.** `ioctl_wait` is registered. It goes to 1 when `count` ≥ DEPTH−2 and to 0 when `count` ≤ DEPTH−4. The hysteresis band is inclusive.
- **busy** = (`count` != 0) | `ram_we`.

## Timing
- All outputs reset to 0. Pointers, count, `last_addr` and `prev_wr` reset to 0.
- Reset mid-operation discards FIFO contents immediately (asynchronous). `ram_we` drops in the same instant.
- Latency: byte pushed at edge T appears with `ram_we`=1 after edge T+1 at the earliest (FIFO empty, `cpu_busy`=0 at T+1). Each cycle of `cpu_busy`=1 adds one cycle.
- `ioctl_wait` updates one cycle after the count crossing.
- Sustained throughput: one byte per cycle with `cpu_busy`=0.

## Configuration
- `TAPE_WRITE_CHECKSUM_EN` defined:
  - `wr_sum` is the 8-bit wrapping sum of `ram_din` over every `ram_we` cycle.
  - `wr_count` increments per `ram_we` and saturates at 16'hFFFF.
  - Both clear on reset and on a `tape_wr` rising edge (new file). Clear has priority over an update in the same cycle.
- Undefined: `wr_sum` and `wr_count` are tied to 0 and no accumulator logic is generated. The port list is identical in both cases.

## Test plan
- **Single byte.** `tape_wr` rises with addr 16'h694D, data 8'hA5, `cpu_busy`=0 -> `ram_we` pulses once, one cycle later, with 16'h694D/8'hA5. `busy` returns to 0 after it.
- **Level hold.** `tape_wr` is held high for 10 cycles at a constant addr/data -> exactly one `ram_we`.
- **Address stream.** Then addr 16'h694E, 16'h694F with data 01, 02 -> two further commits in order.
- **CPU contention.** Push 3 bytes while `cpu_busy`=1 for 20 cycles -> no `ram_we` during that time. After release, 3 consecutive `ram_we` cycles in push order; `ioctl_wait` stays 0.
- **Throttle/overflow.** DEPTH=8, `cpu_busy`=1, push 9 distinct bytes -> `ioctl_wait`=1 one cycle after the 6th push. The 9th byte is dropped and `overflow`=1. After release, 8 commits occur and `ioctl_wait` falls when count reaches 4.
- **Full with simultaneous push/pop.** FIFO full, `cpu_busy` falls in the same cycle as a push -> no drop, `overflow` stays 0, count stays 8.
- **Checksum and reset.** With `TAPE_WRITE_CHECKSUM_EN`, commit bytes FF, 02, 10 -> `wr_sum`=8'h11, `wr_count`=3. A new `tape_wr` rising edge clears both. Asserting `reset_n`=0 mid-stream zeroes all outputs at once; no `ram_we` occurs until new pushes arrive.

Source files
------------

// File: rtl/tape_ram_writer_if.sv
// rtl/tape_ram_writer_if.sv - loader write stream and RAM write port bundle for tape_ram_writer
interface tape_ram_writer_if #(
    parameter int AW = 16
);
    logic          tape_wr;
    logic [AW-1:0] tape_addr;
    logic [7:0]    tape_dout;
    logic          cpu_busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;

    modport master (
        output tape_wr, tape_addr, tape_dout, cpu_busy,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  tape_wr, tape_addr, tape_dout, cpu_busy,
        output ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/tape_ram_writer.sv
// rtl/tape_ram_writer.sv - buffers tape loader bytes in a FIFO and commits them to RAM when the CPU is idle
// Optional running checksum/count of committed bytes: define TAPE_WRITE_CHECKSUM_EN.
module tape_ram_writer #(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    tape_ram_writer_if.slave    bus,
    output logic                ioctl_wait,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          wr_sum,
    output logic [15:0]         wr_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] WAIT_HI = PW'(DEPTH - 2);
    localparam logic [PW-1:0] WAIT_LO = PW'(DEPTH - 4);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          prev_wr_q, prev_wr_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_din_q, ram_din_d;
    logic          ioctl_wait_q, ioctl_wait_d;
    logic          overflow_q, overflow_d;

    logic push, pop, full, do_write;

    always_comb begin
        push     = bus.tape_wr && (!prev_wr_q || (bus.tape_addr != last_addr_q));
        pop      = (count_q != '0) && !bus.cpu_busy;
        full     = (count_q == DEPTH_C);
        // Popping frees the head slot this cycle, so a full FIFO can still take a byte.
        do_write = push && (!full || pop);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_addr_d  = last_addr_q;
        prev_wr_d    = bus.tape_wr;
        ram_we_d     = pop;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ioctl_wait_d = ioctl_wait_q;
        overflow_d   = overflow_q;

        if (push) begin
            last_addr_d = bus.tape_addr;
        end
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            ram_addr_d = mem_addr[rd_ptr_q[IW-1:0]];
            ram_din_d  = mem_data[rd_ptr_q[IW-1:0]];
        end
        case ({do_write, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
        // Hysteresis keeps the HPS throttle from chattering around a single threshold.
        if (count_q >= WAIT_HI) begin
            ioctl_wait_d = 1'b1;
        end else if (count_q <= WAIT_LO) begin
            ioctl_wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_addr[wr_ptr_q[IW-1:0]] <= bus.tape_addr;
            mem_data[wr_ptr_q[IW-1:0]] <= bus.tape_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_addr_q  <= '0;
            prev_wr_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ioctl_wait_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_addr_q  <= last_addr_d;
            prev_wr_q    <= prev_wr_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ioctl_wait_q <= ioctl_wait_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign ioctl_wait   = ioctl_wait_q;
    assign overflow     = overflow_q;
    assign busy         = (count_q != '0) | ram_we_q;

`ifdef TAPE_WRITE_CHECKSUM_EN
    logic [7:0]  wr_sum_q, wr_sum_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        new_file;

    always_comb begin
        // A rising tape_wr marks the start of a new file and wins over a same-cycle commit.
        new_file   = bus.tape_wr && !prev_wr_q;
        wr_sum_d   = wr_sum_q;
        wr_count_d = wr_count_q;
        if (new_file) begin
            wr_sum_d   = '0;
            wr_count_d = '0;
        end else if (ram_we_q) begin
            wr_sum_d = wr_sum_q + ram_din_q;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sum_q   <= '0;
            wr_count_q <= '0;
        end else begin
            wr_sum_q   <= wr_sum_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_sum   = wr_sum_q;
    assign wr_count = wr_count_q;
`else
    assign wr_sum   = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_tape_ram_writer.sv
// tb/tb_tape_ram_writer.sv - self-checking bench for tape_ram_writer with a commit scoreboard
module tb_tape_ram_writer;
    logic        clk;
    logic        reset_n;
    logic        ioctl_wait;
    logic        busy;
    logic        overflow;
    logic [7:0]  wr_sum;
    logic [15:0] wr_count;

    int checks = 0;
    int fails  = 0;

    logic [23:0] sb_q [$];

    tape_ram_writer_if #(.AW(16)) bus ();

    tape_ram_writer #(.DEPTH(8), .AW(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .ioctl_wait (ioctl_wait),
        .busy       (busy),
        .overflow   (overflow),
        .wr_sum     (wr_sum),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        push;
        logic        exp_we;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [15:0] addr, input logic [7:0] data, input logic expect_commit);
        bus.tape_wr   = wr;
        bus.tape_addr = addr;
        bus.tape_dout = data;
        if (expect_commit) sb_q.push_back({addr, data});
    endtask

    // Every RAM write strobe must match the oldest byte the bench expects to be committed.
    always @(posedge clk) begin
        #1;
        if (reset_n && bus.ram_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_commit: got %0h/%0h expected no ram_we", bus.ram_addr, bus.ram_din);
            end else begin
                chk("commit_addr_data", {8'h00, bus.ram_addr, bus.ram_din}, {8'h00, sb_q.pop_front()});
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h694D, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 16'h694D, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 16'h694E, 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'h694F, 8'h02, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h694F, 8'h02, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 16'h694F, 8'h02, 1'b0, 1'b0, 1'b0};

        reset_n      = 1'b0;
        bus.cpu_busy = 1'b0;
        drive(1'b0, 16'h0000, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_sum", wr_sum, 0);
        chk("rst_wr_count", wr_count, 0);
        reset_n = 1'b1;

        // Single byte, level hold, address stream.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].push);
            tick();
            chk($sformatf("vec%0d_ram_we", i), bus.ram_we, vecs[i].exp_we);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_wait", i), ioctl_wait, 0);
        end

        // CPU contention: 3 bytes held for 20 cycles, then drained back to back.
        bus.cpu_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h1000 + 16'(k), 8'h30 + 8'(k), 1'b1);
            tick();
            chk("contend_no_we", bus.ram_we, 0);
        end
        bus.tape_wr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("contend_no_we", bus.ram_we, 0);
            chk("contend_wait", ioctl_wait, 0);
        end
        bus.cpu_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("contend_drain_we", bus.ram_we, 1);
            chk("contend_drain_wait", ioctl_wait, 0);
        end
        tick();
        chk("contend_done_we", bus.ram_we, 0);
        chk("contend_done_busy", busy, 0);

        // Throttle and overflow: 9 pushes into an 8-deep FIFO with the CPU holding RAM.
        bus.cpu_busy = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 16'h1100 + 16'(k), 8'h40 + 8'(k), k <= 8);
            tick();
            if (k == 6) chk("wait_after_push6", ioctl_wait, 0);
            if (k == 7) chk("wait_cycle_after_push6", ioctl_wait, 1);
            chk($sformatf("overflow_push%0d", k), overflow, k == 9);
        end
        bus.tape_wr  = 1'b0;
        bus.cpu_busy = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            tick();
            chk("throttle_drain_we", bus.ram_we, 1);
            chk($sformatf("throttle_wait_pop%0d", r), ioctl_wait, r <= 4);
        end
        tick();
        chk("throttle_done_we", bus.ram_we, 0);
        chk("overflow_sticky", overflow, 1);

        reset_n = 1'b0;
        #1;
        chk("reset_clears_overflow", overflow, 0);
        tick();
        reset_n = 1'b1;

        // Full FIFO: push in the same cycle the CPU releases the port.
        bus.cpu_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'h1200 + 16'(k), 8'h50 + 8'(k), 1'b1);
            tick();
        end
        drive(1'b1, 16'h1208, 8'h58, 1'b1);
        bus.cpu_busy = 1'b0;
        tick();
        chk("full_pushpop_overflow", overflow, 0);
        chk("full_pushpop_we", bus.ram_we, 1);
        bus.tape_wr = 1'b0;
        for (int r = 0; r < 8; r++) begin
            tick();
            chk("full_drain_we", bus.ram_we, 1);
        end
        tick();
        chk("full_done_we", bus.ram_we, 0);
        chk("full_done_busy", busy, 0);
        chk("full_done_overflow", overflow, 0);

        // Checksum over FF, 02, 10.
        drive(1'b1, 16'h2000, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 16'h2001, 8'h02, 1'b1);
        tick();
        drive(1'b1, 16'h2002, 8'h10, 1'b1);
        tick();
        bus.tape_wr = 1'b0;
        for (int k = 0; k < 4; k++) tick();
`ifdef TAPE_WRITE_CHECKSUM_EN
        chk("checksum_sum", wr_sum, 8'h11);
        chk("checksum_count", wr_count, 3);
`else
        chk("checksum_sum_tied", wr_sum, 0);
        chk("checksum_count_tied", wr_count, 0);
`endif
        drive(1'b1, 16'h3000, 8'h55, 1'b1);
        tick();
        chk("newfile_clears_sum", wr_sum, 0);
        chk("newfile_clears_count", wr_count, 0);

        // Mid-stream asynchronous reset while a commit is on the RAM port.
        bus.cpu_busy = 1'b1;
        drive(1'b1, 16'h3001, 8'h66, 1'b0);
        tick();
        drive(1'b1, 16'h3002, 8'h77, 1'b0);
        tick();
        bus.cpu_busy = 1'b0;
        tick();
        chk("pre_reset_we", bus.ram_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        chk("async_reset_we", bus.ram_we, 0);
        chk("async_reset_addr_din", {bus.ram_addr, bus.ram_din}, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_wait", ioctl_wait, 0);
        chk("async_reset_overflow", overflow, 0);
        chk("async_reset_sum_count", {wr_sum, wr_count}, 0);
        bus.tape_wr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_reset_no_we", bus.ram_we, 0);
        end

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
